// File: rtl/cacheline_burst_adaptor_if.sv
// Bundles the cache-side line port and the memory-side 64-bit burst port.
// slave faces the adaptor, master faces whoever drives the cache and memory sides.
interface cacheline_burst_adaptor_if;
  logic [255:0] line_i;
  logic [255:0] line_o;
  logic [31:0]  address_i;
  logic         read_i;
  logic         write_i;
  logic         resp_o;
  logic [63:0]  burst_i;
  logic [63:0]  burst_o;
  logic [31:0]  address_o;
  logic         read_o;
  logic         write_o;
  logic         resp_i;

  modport slave (
    input  line_i, address_i, read_i, write_i, burst_i, resp_i,
    output line_o, resp_o, burst_o, address_o, read_o, write_o
  );

  modport master (
    output line_i, address_i, read_i, write_i, burst_i, resp_i,
    input  line_o, resp_o, burst_o, address_o, read_o, write_o
  );
endinterface

// File: rtl/cacheline_burst_adaptor.sv
// Splits 256-bit cache line fills/writebacks into four 64-bit memory beats, beat 0 = bits [63:0].
// resp_o pulses one cycle after the 4th accepted beat; resp_i low stalls the burst indefinitely.
module cacheline_burst_adaptor #(
  parameter int BEATS = 4
) (
  input logic                       clk,
  input logic                       rst,
  cacheline_burst_adaptor_if.slave  bus
);

  localparam logic [1:0] LAST_BEAT = 2'(BEATS - 1);

  typedef enum logic [1:0] {IDLE, READ, WRITE, DONE} state_t;

  state_t        state, state_nxt;
  logic [1:0]    cnt, cnt_nxt;
  logic [31:0]   addr_q, addr_nxt;
  logic [255:0]  line_buf, line_buf_nxt;
  logic [255:0]  fill_q, fill_nxt;
  logic          read_q, write_q, resp_q;
  logic [7:0]    beat_lsb;
  logic          unused_addr_lsb;

  assign beat_lsb        = {cnt, 6'b0};
  assign unused_addr_lsb = ^bus.address_i[4:0];

  always_comb begin
    state_nxt    = state;
    cnt_nxt      = cnt;
    addr_nxt     = addr_q;
    line_buf_nxt = line_buf;
    fill_nxt     = fill_q;
    case (state)
      IDLE: begin
        // A writeback wins over a simultaneous fill; the fill is picked up after DONE.
        if (bus.write_i) begin
          line_buf_nxt = bus.line_i;
          addr_nxt     = {bus.address_i[31:5], 5'b0};
          cnt_nxt      = 2'd0;
          state_nxt    = WRITE;
        end else if (bus.read_i) begin
          addr_nxt  = {bus.address_i[31:5], 5'b0};
          cnt_nxt   = 2'd0;
          state_nxt = READ;
        end
      end
      READ: begin
        if (bus.resp_i) begin
          line_buf_nxt[beat_lsb +: 64] = bus.burst_i;
          cnt_nxt = cnt + 2'd1;
          if (cnt == LAST_BEAT) begin
            // line_o only moves once the whole line has arrived.
            fill_nxt  = line_buf_nxt;
            state_nxt = DONE;
          end
        end
      end
      WRITE: begin
        if (bus.resp_i) begin
          cnt_nxt = cnt + 2'd1;
          if (cnt == LAST_BEAT) begin
            state_nxt = DONE;
          end
        end
      end
      DONE: begin
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      cnt      <= 2'd0;
      addr_q   <= 32'd0;
      line_buf <= 256'd0;
      fill_q   <= 256'd0;
      read_q   <= 1'b0;
      write_q  <= 1'b0;
      resp_q   <= 1'b0;
    end else begin
      state    <= state_nxt;
      cnt      <= cnt_nxt;
      addr_q   <= addr_nxt;
      line_buf <= line_buf_nxt;
      fill_q   <= fill_nxt;
      read_q   <= (state_nxt == READ);
      write_q  <= (state_nxt == WRITE);
      resp_q   <= (state_nxt == DONE);
    end
  end

  assign bus.read_o    = read_q;
  assign bus.write_o   = write_q;
  assign bus.resp_o    = resp_q;
  assign bus.address_o = addr_q;
  assign bus.line_o    = fill_q;
  assign bus.burst_o   = write_q ? line_buf[beat_lsb +: 64] : 64'd0;

endmodule

// File: tb/tb_cacheline_burst_adaptor.sv
// Scoreboard bench: the cache driver queues expected lines, a memory model feeds beats,
// and a negedge monitor checks every completion, beat and idle cycle against the queue.
module tb_cacheline_burst_adaptor;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  cacheline_burst_adaptor_if bus();

  cacheline_burst_adaptor #(.BEATS(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    bit           wr;
    logic [31:0]  addr;
    logic [255:0] line;
  } exp_t;

  exp_t        exp_q[$];
  logic [63:0] rd_beats[$];
  logic [63:0] wr_beats[$];
  bit          pat[$];
  int          checks = 0;
  int          errors = 0;
  logic [255:0] model_line = '0;
  int          beats = 0;
  bit          resp_due = 1'b0;

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  function automatic logic [255:0] rand_line();
    logic [255:0] v;
    for (int i = 0; i < 8; i++) v[i*32 +: 32] = $urandom;
    return v;
  endfunction

  // A fill of line l arrives as beats l[63:0], l[127:64], ... in that order.
  task automatic queue_read(input logic [31:0] a, input logic [255:0] l);
    exp_t e;
    for (int k = 0; k < 4; k++) rd_beats.push_back(l[k*64 +: 64]);
    e.wr = 1'b0; e.addr = a & ~32'h1F; e.line = l;
    exp_q.push_back(e);
  endtask

  task automatic wait_resp();
    int n;
    n = 0;
    do begin
      @(posedge clk); #1;
      n++;
    end while (!bus.resp_o && n < 400);
    chk("resp_timeout", bus.resp_o, 1);
  endtask

  task automatic do_txn(input bit wr, input bit rd, input logic [31:0] a, input logic [255:0] l);
    exp_t e;
    @(posedge clk); #1;
    bus.address_i = a;
    bus.line_i    = l;
    bus.write_i   = wr;
    bus.read_i    = rd;
    if (wr) begin
      e.wr = 1'b1; e.addr = a & ~32'h1F; e.line = l;
      exp_q.push_back(e);
    end else begin
      queue_read(a, l);
    end
    @(negedge clk);
    chk("pre_accept", {bus.read_o, bus.write_o}, 2'b00);
    @(negedge clk);
    chk("accept", {bus.read_o, bus.write_o}, wr ? 2'b01 : 2'b10);
    wait_resp();
    bus.write_i = 1'b0;
    if (wr && rd) begin
      // read_i is still held: the fill starts from IDLE right after DONE.
      queue_read(a, rand_line());
      @(negedge clk);
      @(negedge clk);
      chk("held_read_idle", {bus.read_o, bus.write_o}, 2'b00);
      @(negedge clk);
      chk("held_read_accept", {bus.read_o, bus.write_o}, 2'b10);
      wait_resp();
    end
    bus.read_i = 1'b0;
  endtask

  // Memory side: strobes resp_i (pattern first while busy, else random) and supplies fill beats.
  initial begin
    bit r;
    bus.resp_i  = 1'b0;
    bus.burst_i = '0;
    forever begin
      @(posedge clk); #1;
      if (bus.read_o || bus.write_o) begin
        if (pat.size() > 0) r = pat.pop_front();
        else r = ($urandom_range(0, 9) < 6);
      end else begin
        r = 1'($urandom_range(0, 1));
      end
      bus.resp_i = r;
      if (bus.read_o && r && rd_beats.size() > 0) bus.burst_i = rd_beats.pop_front();
      else bus.burst_i = {$urandom, $urandom};
    end
  end

  // Monitor
  initial begin
    exp_t e;
    logic [255:0] asm_line;
    forever begin
      @(negedge clk);
      if (rst) begin
        beats = 0; resp_due = 1'b0; exp_q.delete(); wr_beats.delete(); model_line = '0;
      end else begin
        chk("resp_timing", bus.resp_o, resp_due);
        if (resp_due) chk("req_drop_after_last", {bus.read_o, bus.write_o}, 2'b00);
        resp_due = 1'b0;
        if (exp_q.size() == 0) begin
          chk("idle_quiet", {bus.read_o, bus.write_o, bus.resp_o}, 3'b000);
          chk("line_hold", bus.line_o, model_line);
        end else if (bus.resp_o) begin
          e = exp_q.pop_front();
          chk("resp_addr", bus.address_o, e.addr);
          if (e.wr) begin
            chk("wb_beat_count", wr_beats.size(), 4);
            asm_line = '0;
            for (int k = 0; k < 4 && k < wr_beats.size(); k++) asm_line[k*64 +: 64] = wr_beats[k];
            chk("wb_line", asm_line, e.line);
            chk("line_hold", bus.line_o, model_line);
          end else begin
            chk("fill_line", bus.line_o, e.line);
            model_line = e.line;
          end
          wr_beats.delete();
        end else begin
          chk("line_hold", bus.line_o, model_line);
          if (bus.read_o || bus.write_o) begin
            chk("direction", {bus.read_o, bus.write_o}, exp_q[0].wr ? 2'b01 : 2'b10);
            chk("busy_addr", bus.address_o, exp_q[0].addr);
          end
        end
        if ((bus.read_o || bus.write_o) && bus.resp_i) begin
          if (bus.write_o) wr_beats.push_back(bus.burst_o);
          beats++;
          if (beats == 4) begin
            beats = 0;
            resp_due = 1'b1;
          end
        end
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [255:0] l;
    int kind;
    bus.line_i = '0; bus.address_i = '0; bus.read_i = 1'b0; bus.write_i = 1'b0;
    rst = 1'b0;
    #1 rst = 1'b1;
    #2;
    chk("reset_ctl", {bus.read_o, bus.write_o, bus.resp_o}, 3'b000);
    chk("reset_addr", bus.address_o, 32'h0);
    chk("reset_burst", bus.burst_o, 64'h0);
    chk("reset_line", bus.line_o, 256'h0);
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    do_txn(1'b0, 1'b1, 32'h1234_5678, {64'h3, 64'h2, 64'h1, 64'h0});
    chk("dir_read_line", bus.line_o, {64'h3, 64'h2, 64'h1, 64'h0});
    chk("dir_read_addr", bus.address_o, 32'h1234_5660);

    l = {{15{16'hAAAA}}, 16'h0001};
    do_txn(1'b1, 1'b0, 32'h0000_1F3C, l);
    chk("dir_write_keeps_line", bus.line_o, {64'h3, 64'h2, 64'h1, 64'h0});

    pat = {1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
    do_txn(1'b0, 1'b1, $urandom, rand_line());

    do_txn(1'b1, 1'b1, $urandom, rand_line());

    // Reset after three fill beats: no completion, everything cleared at once.
    pat = {1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    @(posedge clk); #1;
    bus.read_i = 1'b1;
    bus.address_i = 32'hCAFE_F00D;
    queue_read(32'hCAFE_F00D, rand_line());
    repeat (4) @(posedge clk);
    @(negedge clk);
    chk("mid_burst_busy", bus.read_o, 1'b1);
    #2 rst = 1'b1;
    #1;
    chk("abort_ctl", {bus.read_o, bus.write_o, bus.resp_o}, 3'b000);
    chk("abort_addr", bus.address_o, 32'h0);
    chk("abort_burst", bus.burst_o, 64'h0);
    chk("abort_line", bus.line_o, 256'h0);
    bus.read_i = 1'b0;
    pat.delete();
    rd_beats.delete();
    @(negedge clk);
    @(posedge clk); #1 rst = 1'b0;
    do_txn(1'b0, 1'b1, $urandom, rand_line());

    repeat (20) @(posedge clk);

    for (int i = 0; i < 40; i++) begin
      kind = $urandom_range(0, 3);
      do_txn(kind >= 2, kind != 2, $urandom, rand_line());
      if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 4)) @(posedge clk);
    end

    repeat (5) @(posedge clk);
    chk("scoreboard_empty", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
